br_resolve: RTL and testbench

Branch resolution unit for the RISC-V pipeline. It sits between IF, EX, the branch predictor and PC_REG. It records the prediction attached to every instruction leaving IF in an in-order queue, pairs each EX completion with the oldest queued prediction, and sends the registered training update (is_br, addr_ex, jmp_addr, jmp) back to the predictor. On a wrong prediction it issues a one-cycle flush and redirect to PC_REG and empties the queue.

---
 rtl/br_resolve.sv | 177 +++++++++++++++++
 tb/tb_br_resolve.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve.sv
// br_resolve: pairs EX completions with queued IF predictions, trains the predictor,
// and issues a one-cycle flush/redirect on a misprediction.
`default_nettype none

module br_resolve #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_push,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_br_p,
    input  logic [ADDR_W-1:0] if_addr_p,
    output logic              q_full,
    input  logic              ex_valid,
    input  logic              ex_is_br,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_jmp,
    input  logic [ADDR_W-1:0] ex_target,
    output logic              upd_is_br,
    output logic [ADDR_W-1:0] upd_addr_ex,
    output logic [ADDR_W-1:0] upd_jmp_addr,
    output logic              upd_jmp,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_miss,
    output logic              err_order
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_q_pc    [DEPTH];
    logic              r_q_brp   [DEPTH];
    logic [ADDR_W-1:0] r_q_addrp [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              r_upd_is_br;
    logic [ADDR_W-1:0] r_upd_addr_ex;
    logic [ADDR_W-1:0] r_upd_jmp_addr;
    logic              r_upd_jmp;
    logic [ADDR_W-1:0] r_redirect;
    logic [STAT_W-1:0] r_stat_br;
    logic [STAT_W-1:0] r_stat_miss;
    logic              r_err_order;

    logic              w_run;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_miss;
    logic              w_err;
    logic              w_br_pop;
    logic [ADDR_W-1:0] w_head_pc;
    logic [ADDR_W-1:0] w_pred;
    logic [ADDR_W-1:0] w_actual;

    // Datapath decode; a mispredicted pop also discards any same-cycle push.
    always_comb begin
        w_run     = (r_state == S_RUN);
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == '0);
        w_head_pc = r_q_pc[r_head];
        w_pred    = r_q_brp[r_head] ? r_q_addrp[r_head] : (w_head_pc + ADDR_W'(4));
        w_actual  = (ex_is_br && ex_jmp) ? ex_target : (ex_pc + ADDR_W'(4));
        w_pop     = ex_valid && !w_empty && w_run;
        w_br_pop  = w_pop && ex_is_br;
        w_miss    = w_pop && (w_pred != w_actual);
        w_push    = if_push && !w_full && w_run && !w_miss;
        w_err     = ex_valid && w_run && (w_empty || (ex_pc != w_head_pc));
    end

    always_comb begin
        w_state_nxt = r_state;
        flush       = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_miss) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush       = 1'b1;
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entry storage needs no reset: occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= if_pc;
            r_q_brp[r_tail]   <= if_br_p;
            r_q_addrp[r_tail] <= if_addr_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_miss) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_is_br    <= 1'b0;
            r_upd_addr_ex  <= '0;
            r_upd_jmp_addr <= '0;
            r_upd_jmp      <= 1'b0;
            r_redirect     <= '0;
            r_stat_br      <= '0;
            r_stat_miss    <= '0;
            r_err_order    <= 1'b0;
        end else begin
            r_upd_is_br    <= w_br_pop;
            r_upd_addr_ex  <= w_br_pop ? ex_pc : '0;
            r_upd_jmp_addr <= w_br_pop ? ex_target : '0;
            r_upd_jmp      <= w_br_pop && ex_jmp;
            r_redirect     <= w_miss ? w_actual : '0;
            if (w_br_pop && (r_stat_br != '1)) begin
                r_stat_br <= r_stat_br + STAT_W'(1);
            end
            if (w_miss && (r_stat_miss != '1)) begin
                r_stat_miss <= r_stat_miss + STAT_W'(1);
            end
            if (w_err) begin
                r_err_order <= 1'b1;
            end
        end
    end

    assign q_full       = w_full;
    assign upd_is_br    = r_upd_is_br;
    assign upd_addr_ex  = r_upd_addr_ex;
    assign upd_jmp_addr = r_upd_jmp_addr;
    assign upd_jmp      = r_upd_jmp;
    assign redirect_pc  = r_redirect;
    assign stat_br      = r_stat_br;
    assign stat_miss    = r_stat_miss;
    assign err_order    = r_err_order;

endmodule

`default_nettype wire

// File: tb/tb_br_resolve.sv
// tb_br_resolve: directed scenario tests for br_resolve with hand-computed expectations.
`default_nettype none

module tb_br_resolve;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int STAT_W = 8;

    logic              clk;
    logic              rst;
    logic              if_push;
    logic [ADDR_W-1:0] if_pc;
    logic              if_br_p;
    logic [ADDR_W-1:0] if_addr_p;
    logic              q_full;
    logic              ex_valid;
    logic              ex_is_br;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_jmp;
    logic [ADDR_W-1:0] ex_target;
    logic              upd_is_br;
    logic [ADDR_W-1:0] upd_addr_ex;
    logic [ADDR_W-1:0] upd_jmp_addr;
    logic              upd_jmp;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [STAT_W-1:0] stat_br;
    logic [STAT_W-1:0] stat_miss;
    logic              err_order;

    int checks;
    int errors;

    br_resolve #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .if_push(if_push), .if_pc(if_pc), .if_br_p(if_br_p), .if_addr_p(if_addr_p),
        .q_full(q_full),
        .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc), .ex_jmp(ex_jmp),
        .ex_target(ex_target),
        .upd_is_br(upd_is_br), .upd_addr_ex(upd_addr_ex), .upd_jmp_addr(upd_jmp_addr),
        .upd_jmp(upd_jmp), .flush(flush), .redirect_pc(redirect_pc),
        .stat_br(stat_br), .stat_miss(stat_miss), .err_order(err_order)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_push = 1'b0; if_pc = '0; if_br_p = 1'b0; if_addr_p = '0;
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_pc = '0; ex_jmp = 1'b0; ex_target = '0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] pc, input logic brp, input logic [ADDR_W-1:0] ap);
        if_push = 1'b1; if_pc = pc; if_br_p = brp; if_addr_p = ap;
    endtask

    task automatic resolve(input logic isbr, input logic [ADDR_W-1:0] pc, input logic jmp,
                           input logic [ADDR_W-1:0] tgt);
        ex_valid = 1'b1; ex_is_br = isbr; ex_pc = pc; ex_jmp = jmp; ex_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL rst_q_full: got %0h want 0", q_full); end
        checks++; if ({upd_is_br, upd_jmp, flush, err_order} !== 4'b0) begin errors++;
            $display("FAIL rst_flags: got %b want 0000", {upd_is_br, upd_jmp, flush, err_order}); end
        checks++; if ({upd_addr_ex, upd_jmp_addr, redirect_pc} !== '0) begin errors++;
            $display("FAIL rst_addrs: got %0h %0h %0h want 0", upd_addr_ex, upd_jmp_addr, redirect_pc); end
        checks++; if ({stat_br, stat_miss} !== '0) begin errors++;
            $display("FAIL rst_stats: got %0h %0h want 0 0", stat_br, stat_miss); end
    endtask

    task automatic test_correct_nt();
        do_reset();
        push(32'h100, 1'b0, 32'h0); tick(); idle();
        resolve(1'b1, 32'h100, 1'b0, 32'h200); tick(); idle();
        checks++; if (upd_is_br !== 1'b1 || upd_addr_ex !== 32'h100 || upd_jmp_addr !== 32'h200 || upd_jmp !== 1'b0) begin
            errors++; $display("FAIL nt_update: got %b %0h %0h %b want 1 100 200 0", upd_is_br, upd_addr_ex, upd_jmp_addr, upd_jmp); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nt_flush: got %b want 0", flush); end
        checks++; if (stat_br !== 8'd1 || stat_miss !== 8'd0) begin errors++;
            $display("FAIL nt_stats: got %0d %0d want 1 0", stat_br, stat_miss); end
        tick();
        checks++; if (upd_is_br !== 1'b0 || upd_addr_ex !== 32'h0) begin errors++;
            $display("FAIL nt_upd_clear: got %b %0h want 0 0", upd_is_br, upd_addr_ex); end
    endtask

    task automatic test_mispredict();
        do_reset();
        push(32'h100, 1'b0, 32'h0); tick();
        push(32'h104, 1'b0, 32'h0); tick(); idle();
        resolve(1'b1, 32'h100, 1'b1, 32'h180); tick(); idle();
        checks++; if (flush !== 1'b1 || redirect_pc !== 32'h180) begin errors++;
            $display("FAIL mp_flush: got %b %0h want 1 180", flush, redirect_pc); end
        checks++; if (upd_is_br !== 1'b1 || upd_jmp !== 1'b1 || upd_jmp_addr !== 32'h180) begin errors++;
            $display("FAIL mp_update: got %b %b %0h want 1 1 180", upd_is_br, upd_jmp, upd_jmp_addr); end
        checks++; if (stat_miss !== 8'd1 || stat_br !== 8'd1) begin errors++;
            $display("FAIL mp_stats: got %0d %0d want 1 1", stat_br, stat_miss); end
        // A push during the flush cycle is ignored.
        push(32'h300, 1'b0, 32'h0); tick(); idle();
        checks++; if (flush !== 1'b0 || redirect_pc !== 32'h0) begin errors++;
            $display("FAIL mp_flush_clear: got %b %0h want 0 0", flush, redirect_pc); end
        resolve(1'b0, 32'h104, 1'b0, 32'h0); tick(); idle();
        checks++; if (err_order !== 1'b1) begin errors++; $display("FAIL mp_err_order: got %b want 1", err_order); end
        checks++; if (upd_is_br !== 1'b0 || flush !== 1'b0 || stat_br !== 8'd1) begin errors++;
            $display("FAIL mp_empty_noop: got %b %b %0d want 0 0 1", upd_is_br, flush, stat_br); end
        tick();
        checks++; if (err_order !== 1'b1) begin errors++; $display("FAIL mp_err_sticky: got %b want 1", err_order); end
    endtask

    task automatic test_full_queue();
        logic [ADDR_W-1:0] pc;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push(32'(4 * i), 1'b0, 32'h0); tick();
        end
        checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", q_full); end
        push(32'h10, 1'b0, 32'h0); tick();
        checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full_drop: got %b want 1", q_full); end
        resolve(1'b0, 32'h0, 1'b0, 32'h0); tick(); idle();
        checks++; if (q_full !== 1'b0 || flush !== 1'b0) begin errors++;
            $display("FAIL full_pushpop: got %b %b want 0 0", q_full, flush); end
        for (int i = 1; i < DEPTH; i++) begin
            pc = 32'(4 * i);
            resolve(1'b1, pc, 1'b0, pc + 32'h100); tick();
            checks++; if (upd_is_br !== 1'b1 || upd_addr_ex !== pc || upd_jmp_addr !== pc + 32'h100) begin errors++;
                $display("FAIL full_pop_order: got %b %0h %0h want 1 %0h %0h", upd_is_br, upd_addr_ex, upd_jmp_addr, pc, pc + 32'h100); end
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL refill_early_full: got %b want 0 at %0d", q_full, i); end
            push(32'h20 + 32'(4 * i), 1'b0, 32'h0); tick();
        end
        idle();
        checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b want 1", q_full); end
        for (int i = 0; i < DEPTH; i++) begin
            pc = 32'h20 + 32'(4 * i);
            resolve(1'b1, pc, 1'b0, 32'h0); tick();
            checks++; if (upd_addr_ex !== pc || flush !== 1'b0) begin errors++;
                $display("FAIL refill_pop: got %0h %b want %0h 0", upd_addr_ex, flush, pc); end
        end
        idle();
        checks++; if (err_order !== 1'b0 || stat_miss !== 8'd0 || stat_br !== 8'd7) begin errors++;
            $display("FAIL full_final: got %b %0d %0d want 0 0 7", err_order, stat_miss, stat_br); end
    endtask

    task automatic test_nonbranch_taken();
        do_reset();
        push(32'h40, 1'b1, 32'h80); tick(); idle();
        resolve(1'b0, 32'h40, 1'b0, 32'h0); tick(); idle();
        checks++; if (flush !== 1'b1 || redirect_pc !== 32'h44) begin errors++;
            $display("FAIL nbt_flush: got %b %0h want 1 44", flush, redirect_pc); end
        checks++; if (upd_is_br !== 1'b0) begin errors++; $display("FAIL nbt_no_upd: got %b want 0", upd_is_br); end
        checks++; if (stat_miss !== 8'd1 || stat_br !== 8'd0) begin errors++;
            $display("FAIL nbt_stats: got %0d %0d want 0 1", stat_br, stat_miss); end
        // Throughput after mispredict: push accepted two cycles after the pop edge.
        tick();
        push(32'h500, 1'b0, 32'h0); tick(); idle();
        resolve(1'b1, 32'h500, 1'b0, 32'h0); tick(); idle();
        checks++; if (upd_is_br !== 1'b1 || upd_addr_ex !== 32'h500 || err_order !== 1'b0) begin errors++;
            $display("FAIL nbt_repush: got %b %0h %b want 1 500 0", upd_is_br, upd_addr_ex, err_order); end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int i = 0; i < (1 << STAT_W) + 3; i++) begin
            push(32'h10, 1'b0, 32'h0); tick(); idle();
            resolve(1'b1, 32'h10, 1'b1, 32'h80); tick(); idle();
            tick();
        end
        checks++; if (stat_miss !== 8'hFF || stat_br !== 8'hFF) begin errors++;
            $display("FAIL sat_stats: got %0h %0h want ff ff", stat_br, stat_miss); end
        push(32'h10, 1'b0, 32'h0); tick(); idle();
        push(32'h14, 1'b0, 32'h0); tick(); idle();
        resolve(1'b1, 32'h10, 1'b1, 32'h80); tick(); idle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL sat_in_flush: got %b want 1", flush); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if ({q_full, upd_is_br, upd_jmp, flush, err_order} !== 5'b0 || redirect_pc !== '0 ||
                      upd_addr_ex !== '0 || upd_jmp_addr !== '0 || stat_br !== '0 || stat_miss !== '0) begin errors++;
            $display("FAIL rst_mid_flush: got %b %0h %0h %0h %0h want all zero",
                     {q_full, upd_is_br, upd_jmp, flush, err_order}, redirect_pc, upd_addr_ex, stat_br, stat_miss); end
        resolve(1'b1, 32'h14, 1'b0, 32'h0); tick(); idle();
        checks++; if (err_order !== 1'b1 || upd_is_br !== 1'b0) begin errors++;
            $display("FAIL rst_queue_empty: got %b %b want 1 0", err_order, upd_is_br); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        test_reset();
        test_correct_nt();
        test_mispredict();
        test_full_queue();
        test_nonbranch_taken();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
